// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO: ramp, square and wrap pulse; increments are applied only on a wrap. Optional NCO_SLEW_EN limits the increment step per wrap.
// Latency: PHASE/WRAP are registered, one CE cycle per step; an accepted increment takes effect at the next wrap (next edge in IDLE).
// Backpressure: INC_READY drops while the single pending slot holds a word; it reopens on the wrap that consumes it.
module nco_phase_gen #(
    parameter int DATA_BITS  = 28,
    parameter int PHASE_BITS = 32,
    parameter int SLEW_SHIFT = 16
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CE,
    input  logic                  ENABLE,
    input  logic [DATA_BITS-1:0]  INC_VALUE,
    input  logic                  INC_VALID,
    output logic                  INC_READY,
    output logic [PHASE_BITS-1:0] PHASE,
    output logic                  SQUARE_OUT,
    output logic                  WRAP,
    output logic [DATA_BITS-1:0]  ACTIVE_INC
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    if (PHASE_BITS < DATA_BITS || SLEW_SHIFT < 0) begin : g_param_check
        $error("nco_phase_gen: PHASE_BITS must be >= DATA_BITS and SLEW_SHIFT >= 0");
    end

    state_t                 state;
    logic                   pend_full;
    logic [DATA_BITS-1:0]   pend_dat;
    logic                   accept;
    logic [PHASE_BITS:0]    inc_ext;
    logic [PHASE_BITS:0]    sum;
    logic                   carry;
    logic [DATA_BITS-1:0]   wrap_inc;
    logic                   wrap_done;

    assign INC_READY  = ~pend_full;
    assign accept     = CE & INC_VALID & ~pend_full;
    assign SQUARE_OUT = PHASE[PHASE_BITS-1];

    assign inc_ext = {{(PHASE_BITS + 1 - DATA_BITS){1'b0}}, ACTIVE_INC};
    assign sum     = {1'b0, PHASE} + inc_ext;
    assign carry   = sum[PHASE_BITS];

`ifdef NCO_SLEW_EN
    // Step is clamped to the word width so a huge SLEW_SHIFT degrades to a whole-word load.
    localparam int SLEW_SH_EFF = (SLEW_SHIFT > DATA_BITS) ? DATA_BITS : SLEW_SHIFT;
    localparam logic [DATA_BITS:0] SLEW_STEP = {{DATA_BITS{1'b0}}, 1'b1} << SLEW_SH_EFF;

    logic                 slew_up;
    logic [DATA_BITS:0]   slew_diff;

    always_comb begin
        slew_up   = pend_dat > ACTIVE_INC;
        slew_diff = slew_up ? ({1'b0, pend_dat} - {1'b0, ACTIVE_INC})
                            : ({1'b0, ACTIVE_INC} - {1'b0, pend_dat});
        wrap_inc  = pend_dat;
        wrap_done = 1'b1;
        if (slew_diff > SLEW_STEP) begin
            wrap_done = 1'b0;
            if (slew_up) begin
                wrap_inc = ACTIVE_INC + SLEW_STEP[DATA_BITS-1:0];
            end else begin
                wrap_inc = ACTIVE_INC - SLEW_STEP[DATA_BITS-1:0];
            end
        end
    end
`else
    assign wrap_inc  = pend_dat;
    assign wrap_done = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            PHASE      <= '0;
            WRAP       <= 1'b0;
            ACTIVE_INC <= '0;
            pend_full  <= 1'b0;
            pend_dat   <= '0;
        end else if (CE) begin
            case (state)
                ST_IDLE: begin
                    PHASE <= '0;
                    WRAP  <= 1'b0;
                    if (accept) begin
                        ACTIVE_INC <= INC_VALUE;
                    end
                    if (ENABLE) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!ENABLE) begin
                        // Leaving RUN: whatever was queued becomes the active word immediately.
                        state     <= ST_IDLE;
                        PHASE     <= '0;
                        WRAP      <= 1'b0;
                        pend_full <= 1'b0;
                        if (pend_full) begin
                            ACTIVE_INC <= pend_dat;
                        end else if (accept) begin
                            ACTIVE_INC <= INC_VALUE;
                        end
                    end else begin
                        PHASE <= sum[PHASE_BITS-1:0];
                        WRAP  <= carry;
                        if (carry && pend_full) begin
                            ACTIVE_INC <= wrap_inc;
                            if (wrap_done) begin
                                pend_full <= 1'b0;
                            end
                        end
                        // accept implies the slot was empty, so it cannot collide with the load above.
                        if (accept) begin
                            pend_dat  <= INC_VALUE;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen: directed scenarios with literal expectations plus randomized traffic against a queue-based model.
module tb_nco_phase_gen;

    localparam int DB = 32;
    localparam int PB = 32;
    localparam int SS = 16;
    localparam longint unsigned MOD  = 64'h1_0000_0000;
    localparam longint unsigned STEP = 64'd1 << SS;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          CE = 1'b0;
    logic          ENABLE = 1'b0;
    logic [DB-1:0] INC_VALUE = '0;
    logic          INC_VALID = 1'b0;
    logic          INC_READY;
    logic [PB-1:0] PHASE;
    logic          SQUARE_OUT;
    logic          WRAP;
    logic [DB-1:0] ACTIVE_INC;

    nco_phase_gen #(
        .DATA_BITS  (DB),
        .PHASE_BITS (PB),
        .SLEW_SHIFT (SS)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .CE         (CE),
        .ENABLE     (ENABLE),
        .INC_VALUE  (INC_VALUE),
        .INC_VALID  (INC_VALID),
        .INC_READY  (INC_READY),
        .PHASE      (PHASE),
        .SQUARE_OUT (SQUARE_OUT),
        .WRAP       (WRAP),
        .ACTIVE_INC (ACTIVE_INC)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;

    // Reference model: phase as a plain integer mod 2^32, pending slot as a queue.
    bit              m_on = 1'b0;
    bit              m_run;
    bit              m_wrap;
    longint unsigned m_phase;
    longint unsigned m_active;
    longint unsigned pend_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_wrap   = 1'b0;
        m_phase  = 0;
        m_active = 0;
        pend_q.delete();
    endtask

    task automatic apply_pending();
        longint unsigned tgt;
        tgt = pend_q[0];
`ifdef NCO_SLEW_EN
        if (tgt > m_active && tgt - m_active > STEP)      m_active = m_active + STEP;
        else if (m_active > tgt && m_active - tgt > STEP) m_active = m_active - STEP;
        else                                              m_active = tgt;
`else
        m_active = tgt;
`endif
        if (m_active == tgt) void'(pend_q.pop_front());
    endtask

    task automatic model_step();
        bit              acc;
        longint unsigned s;
        acc = INC_VALID && (pend_q.size() == 0);
        if (!m_run) begin
            m_phase = 0;
            m_wrap  = 1'b0;
            if (acc) m_active = INC_VALUE;
            if (ENABLE) m_run = 1'b1;
        end else if (!ENABLE) begin
            m_run   = 1'b0;
            m_phase = 0;
            m_wrap  = 1'b0;
            if (pend_q.size() != 0) m_active = pend_q.pop_front();
            else if (acc)           m_active = INC_VALUE;
        end else begin
            s       = m_phase + m_active;
            m_wrap  = (s >= MOD);
            m_phase = s % MOD;
            if (m_wrap && pend_q.size() != 0) apply_pending();
            if (acc) pend_q.push_back(INC_VALUE);
        end
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            model_reset();
        end else if (m_on) begin
            if (CE) model_step();
            #1;
            chk("phase",      PHASE,      m_phase);
            chk("wrap",       WRAP,       m_wrap);
            chk("active_inc", ACTIVE_INC, m_active);
            chk("inc_ready",  INC_READY,  pend_q.size() == 0);
            chk("square",     SQUARE_OUT, m_phase[31]);
        end
    end

    always @(posedge CLK) begin
        if (RESET_N && CE && INC_VALID && INC_READY) hs_cnt++;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_wrap(input int lim, input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!WRAP && n < lim);
        chk({nm, "_wrap_seen"}, WRAP, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        int hs0;
        int wraps;
        model_reset();
        CE = 1'b1;
        repeat (3) tick();
        chk("reset_phase",  PHASE,      0);
        chk("reset_active", ACTIVE_INC, 0);
        chk("reset_ready",  INC_READY,  1);
        chk("reset_wrap",   WRAP,       0);
        RESET_N = 1'b1;
        m_on    = 1'b1;

        // Load 2^30 in IDLE, run: four-cycle period, square 0,0,1,1.
        INC_VALID = 1'b1; INC_VALUE = 32'h4000_0000; tick();
        chk("idle_direct_load", ACTIVE_INC, 32'h4000_0000);
        chk("idle_ready", INC_READY, 1);
        INC_VALID = 1'b0; ENABLE = 1'b1; tick();
        chk("run_entry_phase", PHASE, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("ramp_phase",  PHASE, (longint'(k) * 64'h4000_0000) % MOD);
            chk("ramp_wrap",   WRAP, (k % 4) == 0);
            chk("ramp_square", SQUARE_OUT, (k % 4) == 2 || (k % 4) == 3);
        end

        // Change to 2^29 at PHASE=2^30: held off until the wrap, then period 8.
        tick();
        chk("pre_change_phase", PHASE, 32'h4000_0000);
        INC_VALID = 1'b1; INC_VALUE = 32'h2000_0000; tick();
        INC_VALID = 1'b0;
        chk("pending_ready_a", INC_READY, 0);
        chk("pending_active_a", ACTIVE_INC, 32'h4000_0000);
        tick();
        chk("pending_ready_b", INC_READY, 0);
        tick();
        chk("change_wrap",   WRAP, 1);
        chk("change_phase",  PHASE, 0);
        chk("change_active", ACTIVE_INC, 32'h2000_0000);
        chk("change_ready",  INC_READY, 1);
        n = 0; hi = 0;
        do begin
            tick();
            n++;
            if (SQUARE_OUT) hi++;
        end while (!WRAP && n < 20);
        chk("period_after_change", n, 8);
        chk("square_high_cycles", hi, 4);

        // Transfer coincident with a wrap lands in pending; VALID held high gives one transfer.
        repeat (7) tick();
        chk("pre_coincide_phase", PHASE, 32'hE000_0000);
        hs0 = hs_cnt;
        INC_VALID = 1'b1; INC_VALUE = 32'h4000_0000; tick();
        chk("coincide_wrap",   WRAP, 1);
        chk("coincide_active", ACTIVE_INC, 32'h2000_0000);
        chk("coincide_ready",  INC_READY, 0);
        repeat (3) tick();
        INC_VALID = 1'b0;
        chk("single_transfer", hs_cnt - hs0, 1);
        wait_wrap(20, "coincide");
        chk("coincide_applied", ACTIVE_INC, 32'h4000_0000);

        // 2000 cycles at 109377165 from zero phase.
        ENABLE = 1'b0; tick();
        INC_VALID = 1'b1; INC_VALUE = 32'd109377165; tick();
        INC_VALID = 1'b0; ENABLE = 1'b1; tick();
        wraps = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (WRAP) wraps++;
        end
        chk("long_run_wraps", wraps, 50);
        chk("long_run_phase", PHASE, 32'd4005965200);

        // CE alternating: only CE=1 cycles advance.
        ENABLE = 1'b0; tick();
        INC_VALID = 1'b1; INC_VALUE = 32'h4000_0000; tick();
        INC_VALID = 1'b0; ENABLE = 1'b1; tick();
        for (int k = 0; k < 6; k++) begin
            CE = (k % 2) == 0;
            tick();
        end
        chk("ce_gated_phase", PHASE, 32'hC000_0000);
        chk("ce_gated_wrap",  WRAP, 0);
        CE = 1'b1; INC_VALID = 1'b1; INC_VALUE = 32'd5; tick();
        INC_VALID = 1'b0;
        chk("exact_landing_phase", PHASE, 0);
        chk("exact_landing_wrap",  WRAP, 1);
        chk("exact_landing_ready", INC_READY, 0);
        tick(); tick();
        RESET_N = 1'b0;
        #1;
        chk("async_reset_phase",  PHASE, 0);
        chk("async_reset_active", ACTIVE_INC, 0);
        chk("async_reset_ready",  INC_READY, 1);
        ENABLE = 1'b0;
        tick(); tick();
        RESET_N = 1'b1;
        tick();

`ifdef NCO_SLEW_EN
        INC_VALID = 1'b1; INC_VALUE = 32'd1048576; tick();
        INC_VALID = 1'b0; ENABLE = 1'b1; tick();
        INC_VALID = 1'b1; INC_VALUE = 32'd1048576 + 32'd40000; tick();
        INC_VALID = 1'b0;
        wait_wrap(5000, "slew_small");
        chk("slew_small_active", ACTIVE_INC, 32'd1088576);
        chk("slew_small_ready", INC_READY, 1);
        INC_VALID = 1'b1; INC_VALUE = 32'd1048576 + 32'd200000; tick();
        INC_VALID = 1'b0;
        wait_wrap(5000, "slew_1");
        chk("slew_step1", ACTIVE_INC, 32'd1048576 + 32'd65536);
        chk("slew_step1_ready", INC_READY, 0);
        wait_wrap(5000, "slew_2");
        chk("slew_step2", ACTIVE_INC, 32'd1048576 + 32'd131072);
        wait_wrap(5000, "slew_3");
        chk("slew_step3", ACTIVE_INC, 32'd1048576 + 32'd196608);
        wait_wrap(5000, "slew_4");
        chk("slew_step4", ACTIVE_INC, 32'd1048576 + 32'd200000);
        chk("slew_done_ready", INC_READY, 1);
        ENABLE = 1'b0; tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (!(INC_VALID && !INC_READY)) begin
                INC_VALID = ($urandom_range(0, 3) == 0);
                INC_VALUE = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(32'h0400_0000, 32'h4000_0000));
            end
            CE     = ($urandom_range(0, 7) != 0);
            ENABLE = ($urandom_range(0, 49) != 0);
            if (i == 1500) begin
                RESET_N = 1'b0;
                tick();
                INC_VALID = 1'b0;
                RESET_N = 1'b1;
            end
            tick();
        end
        INC_VALID = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
